pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Game-sequencing controller for the pong graphics datapath. It runs the start screen, the ball launch countdown, play, an optional pause, and game over. It keeps score and the remaining ball count, and tells the graphics block when to freeze motion, when to re-launch the ball, and which text overlay to show. It sits between the VGA sync/graphics animation block and the text/score overlay, and is clocked by the pixel-domain clock.

## Interface
Parameters:
- BALLS_INIT, 3: balls per game; range 1..3.
- LAUNCH_FRAMES, 120: frames frozen before each launch (2 s at 60 Hz); range 1..255.
- OVER_FRAMES, 180: frames the game-over screen is held; range 1..255.

Ports:
- clk  in  1  pixel-domain clock.
- reset  in  1  reset, synchronous, active-high.
- frame_tick  in  1  one-cycle pulse once per frame, at the start of vertical sync.
- btn  in  2  paddle buttons; any nonzero value starts a game from the start screen.
- hit  in  1  one-cycle pulse from graphics: ball bounced off the paddle.
- miss  in  1  one-cycle pulse from graphics: ball passed the paddle edge.
- pause_btn  in  1  pause toggle, level input; present only with PONG_CTRL_PAUSE_EN.
- graph_still  out  1  freezes ball and paddle motion when 1.
- ball_launch  out  1  one-cycle pulse that re-centres and releases the ball.
- score_bcd  out  8  two BCD digits {tens, ones}, range 00..99.
- balls_left  out  2  balls remaining.
- speed_lvl  out  2  ball speed level; equals the tens digit, saturated at 3.
- game_over  out  1  high while in OVER.
- text_sel  out  2  overlay select: 00 none, 01 start, 10 game over, 11 paused.

## Operation
- The state machine has five states: IDLE, LAUNCH, PLAY, OVER and PAUSE. PAUSE exists only with the macro.
- On reset:
  - state goes to IDLE.
  - score_bcd=8'h00, balls_left=BALLS_INIT, timer=0.
  - ball_launch=0, graph_still=1, game_over=0, text_sel=01, speed_lvl=0.
- IDLE:
  - btn!=0 sets score to 00, sets balls_left=BALLS_INIT, loads timer=LAUNCH_FRAMES, and moves to LAUNCH.
- LAUNCH:
  - Each frame_tick decrements the timer.
  - A tick arriving with timer==1 moves the state to PLAY.
  - ball_launch is 1 for exactly the first cycle spent in PLAY after LAUNCH.
- PLAY:
  - hit increments score in BCD: ones digit 9 wraps to 0 with a carry into tens; the score saturates at 99.
  - miss with balls_left>1 decrements balls_left, loads timer=LAUNCH_FRAMES, and moves to LAUNCH.
  - miss with balls_left==1 sets balls_left to 0, loads timer=OVER_FRAMES, and moves to OVER.
  - If hit and miss arrive in the same cycle, miss wins and the hit is dropped.
- OVER:
  - Each frame_tick decrements the timer.
  - A tick arriving with timer==1 moves the state to IDLE.
  - The score is held through OVER and IDLE until the next game starts.
- hit and miss are ignored in every state other than PLAY. btn is ignored outside IDLE.
- Outputs are Moore-decoded from the registered state:
  - graph_still=0 only in PLAY.
  - game_over=1 only in OVER.
  - text_sel is 01 in IDLE, 10 in OVER, 11 in PAUSE, and 00 otherwise.

## Timing
- All outputs are registered. None has a combinational path from any input.
- btn asserted in IDLE takes effect at the next clock edge: LAUNCH is entered one cycle later.
- LAUNCH lasts exactly LAUNCH_FRAMES frame_ticks. PLAY starts on the clock edge that samples the final tick. OVER behaves the same way with OVER_FRAMES.
- score_bcd and speed_lvl update one cycle after the hit pulse.
- balls_left and the state update one cycle after the miss pulse.
- The timer is 8 bits. It is never decremented below 0, and frame_tick has no effect on it in IDLE or PLAY.
- reset asserted in any state, mid-countdown included, forces the reset values at the next edge. A pending ball_launch is cancelled.
- If frame_tick and a state-changing input arrive in the same cycle, the state-changing input is evaluated first. The tick is not applied to the newly loaded timer.

## Configuration
- PONG_CTRL_PAUSE_EN defined:
  - The pause_btn port exists and is registered once for edge detection.
  - A rising edge in PLAY moves to PAUSE: graph_still=1, text_sel=11.
  - A rising edge in PAUSE returns to PLAY. ball_launch is not pulsed on resume.
  - hit and miss are ignored in PAUSE.
  - The edge-detect register resets to 0.
- Not defined: the pause_btn port and the PAUSE state are absent, and text_sel never equals 11.

## Test plan
All scenarios use BALLS_INIT=3, LAUNCH_FRAMES=4, OVER_FRAMES=3.
- Reset, hold btn=0 for 10 frames -> remains IDLE, text_sel=01, graph_still=1, score_bcd=00, balls_left=3.
- btn=01 for one cycle, then 4 frame_ticks -> PLAY entered on the 4th tick, exactly one ball_launch pulse, graph_still=0.
- 12 hit pulses in PLAY -> score_bcd=8'h12, speed_lvl=1. Preload 98 with 3 more hits -> score_bcd=8'h99.
- hit and miss in the same cycle with balls_left=3 -> score unchanged, balls_left=2, state LAUNCH. After 3 misses in total -> game_over=1, text_sel=10, then IDLE after 3 ticks.
- reset asserted at LAUNCH timer=2 -> next cycle IDLE with all reset values, and no ball_launch pulse ever.
- With PONG_CTRL_PAUSE_EN: pause edge in PLAY -> text_sel=11, graph_still=1, and a miss pulse is ignored (balls_left unchanged). A second edge -> PLAY with no ball_launch pulse.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game sequencer for pong (start screen, launch countdown, play, optional pause, game over)
// Ports:
//   clk, reset            pixel clock, synchronous active-high reset
//   frame_tick            one-cycle pulse per frame (start of vsync)
//   btn[1:0]              paddle buttons, any nonzero starts a game from IDLE
//   hit, miss             one-cycle pulses from the graphics block
//   pause_btn             pause toggle level (only with PONG_CTRL_PAUSE_EN)
//   graph_still           freeze motion
//   ball_launch           one-cycle pulse on entering PLAY from LAUNCH
//   score_bcd[7:0]        {tens, ones} BCD score, saturates at 99
//   balls_left[1:0]       balls remaining
//   speed_lvl[1:0]        tens digit saturated at 3
//   game_over             high in OVER
//   text_sel[1:0]         00 none, 01 start, 10 game over, 11 paused
// Optional feature macro: PONG_CTRL_PAUSE_EN
module pong_game_ctrl #(
    parameter int BALLS_INIT    = 3,
    parameter int LAUNCH_FRAMES = 120,
    parameter int OVER_FRAMES   = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [1:0] btn,
    input  logic       hit,
    input  logic       miss,
`ifdef PONG_CTRL_PAUSE_EN
    input  logic       pause_btn,
`endif
    output logic       graph_still,
    output logic       ball_launch,
    output logic [7:0] score_bcd,
    output logic [1:0] balls_left,
    output logic [1:0] speed_lvl,
    output logic       game_over,
    output logic [1:0] text_sel
);
`ifdef PONG_CTRL_PAUSE_EN
    typedef enum logic [2:0] {IDLE, LAUNCH, PLAY, OVER, PAUSE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LAUNCH, PLAY, OVER} state_t;
`endif
    state_t     state, nxt;
    logic [7:0] timer, nxt_score, score_inc;
    logic       pause_rise, in_pause;
`ifdef PONG_CTRL_PAUSE_EN
    logic pause_q;
    assign pause_rise = pause_btn & ~pause_q;
    assign in_pause   = nxt == PAUSE;
    always_ff @(posedge clk)
        pause_q <= reset ? 1'b0 : pause_btn;
`else
    assign pause_rise = 1'b0;
    assign in_pause   = 1'b0;
`endif
    // BCD increment with saturation at 99
    assign score_inc = score_bcd == 8'h99 ? 8'h99 :
                       score_bcd[3:0] == 4'd9 ? {score_bcd[7:4] + 4'd1, 4'd0} :
                       score_bcd + 8'd1;
    always_comb begin
        nxt       = state;
        nxt_score = score_bcd;
        case (state)
            IDLE: begin
                nxt       = |btn ? LAUNCH : IDLE;
                nxt_score = |btn ? 8'h00 : score_bcd;
            end
            LAUNCH: nxt = frame_tick && timer <= 8'd1 ? PLAY : LAUNCH;
            PLAY: begin
                // miss has priority; a simultaneous hit is dropped
                nxt       = miss ? (balls_left > 2'd1 ? LAUNCH : OVER) : PLAY;
`ifdef PONG_CTRL_PAUSE_EN
                nxt       = !miss && pause_rise ? PAUSE : nxt;
`endif
                nxt_score = !miss && hit ? score_inc : score_bcd;
            end
            OVER: nxt = frame_tick && timer <= 8'd1 ? IDLE : OVER;
`ifdef PONG_CTRL_PAUSE_EN
            PAUSE: nxt = pause_rise ? PLAY : PAUSE;
`endif
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            score_bcd   <= 8'h00;
            balls_left  <= 2'(BALLS_INIT);
            timer       <= 8'd0;
            ball_launch <= 1'b0;
            graph_still <= 1'b1;
            game_over   <= 1'b0;
            text_sel    <= 2'b01;
            speed_lvl   <= 2'd0;
        end else begin
            state       <= nxt;
            score_bcd   <= nxt_score;
            speed_lvl   <= nxt_score[7:4] > 4'd3 ? 2'd3 : nxt_score[5:4];
            ball_launch <= state == LAUNCH && nxt == PLAY;
            graph_still <= nxt != PLAY;
            game_over   <= nxt == OVER;
            text_sel    <= {nxt == OVER || in_pause, nxt == IDLE || in_pause};
            case (state)
                IDLE: if (|btn) begin
                    balls_left <= 2'(BALLS_INIT);
                    timer      <= 8'(LAUNCH_FRAMES);
                end
                LAUNCH, OVER: if (frame_tick && timer != 8'd0) timer <= timer - 8'd1;
                PLAY: if (miss) begin
                    balls_left <= balls_left - 2'd1;
                    timer      <= balls_left > 2'd1 ? 8'(LAUNCH_FRAMES) : 8'(OVER_FRAMES);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed self-checking bench for pong_game_ctrl
module tb_pong_game_ctrl;
    logic       clk = 0, reset = 1, frame_tick = 0, hit = 0, miss = 0;
    logic [1:0] btn = 0;
    logic       graph_still, ball_launch, game_over;
    logic [7:0] score_bcd;
    logic [1:0] balls_left, speed_lvl, text_sel;
    int         checks = 0, errors = 0, launches = 0, snap;
`ifdef PONG_CTRL_PAUSE_EN
    logic pause_btn = 0;
`endif

    pong_game_ctrl #(.BALLS_INIT(3), .LAUNCH_FRAMES(4), .OVER_FRAMES(3)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn),
        .hit(hit), .miss(miss),
`ifdef PONG_CTRL_PAUSE_EN
        .pause_btn(pause_btn),
`endif
        .graph_still(graph_still), .ball_launch(ball_launch), .score_bcd(score_bcd),
        .balls_left(balls_left), .speed_lvl(speed_lvl), .game_over(game_over),
        .text_sel(text_sel)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (ball_launch) launches++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        frame_tick = 1; step(); frame_tick = 0;
    endtask

    initial begin
        step(); step();
        reset = 0;
        chk("rst_text", text_sel, 1);
        chk("rst_still", graph_still, 1);
        chk("rst_score", score_bcd, 8'h00);
        chk("rst_balls", balls_left, 3);
        chk("rst_over", game_over, 0);
        chk("rst_launch", ball_launch, 0);
        chk("rst_speed", speed_lvl, 0);
        for (int i = 0; i < 10; i++) begin tick(); step(); end
        chk("idle_text", text_sel, 1);
        chk("idle_still", graph_still, 1);
        hit = 1; step(); hit = 0;
        chk("idle_hit_ignored", score_bcd, 8'h00);
        btn = 2'b01; step(); btn = 0;
        chk("launch_text", text_sel, 0);
        chk("launch_still", graph_still, 1);
        for (int i = 0; i < 3; i++) tick();
        chk("launch_3ticks_still", graph_still, 1);
        chk("launch_3ticks_nolaunch", ball_launch, 0);
        tick();
        chk("play_still", graph_still, 0);
        chk("play_launch_pulse", ball_launch, 1);
        step();
        chk("play_launch_off", ball_launch, 0);
        chk("launch_count1", launches, 1);
        for (int i = 0; i < 12; i++) begin hit = 1; step(); end
        hit = 0;
        chk("score12", score_bcd, 8'h12);
        chk("speed1", speed_lvl, 1);
        for (int i = 0; i < 86; i++) begin hit = 1; step(); end
        hit = 0;
        chk("score98", score_bcd, 8'h98);
        chk("speed3", speed_lvl, 3);
        for (int i = 0; i < 3; i++) begin hit = 1; step(); end
        hit = 0;
        chk("score_sat99", score_bcd, 8'h99);
        hit = 1; miss = 1; step(); hit = 0; miss = 0;
        chk("hitmiss_score", score_bcd, 8'h99);
        chk("hitmiss_balls", balls_left, 2);
        chk("hitmiss_still", graph_still, 1);
        chk("hitmiss_text", text_sel, 0);
        btn = 2'b11; step(); btn = 0;
        chk("btn_ignored_balls", balls_left, 2);
        for (int i = 0; i < 4; i++) tick();
        chk("relaunch_pulse", ball_launch, 1);
        miss = 1; step(); miss = 0;
        chk("miss2_balls", balls_left, 1);
        for (int i = 0; i < 4; i++) tick();
        chk("play3_still", graph_still, 0);
        miss = 1; step(); miss = 0;
        chk("over_balls", balls_left, 0);
        chk("over_flag", game_over, 1);
        chk("over_text", text_sel, 2);
        chk("over_still", graph_still, 1);
        tick(); tick();
        chk("over_2ticks", game_over, 1);
        tick();
        chk("idle_after_over", text_sel, 1);
        chk("idle_after_over_flag", game_over, 0);
        chk("score_held", score_bcd, 8'h99);
        chk("launch_count3", launches, 3);
        btn = 2'b10; step(); btn = 0;
        chk("newgame_score", score_bcd, 8'h00);
        chk("newgame_balls", balls_left, 3);
        tick(); tick();
        snap = launches;
        reset = 1; step(); reset = 0;
        chk("midrst_text", text_sel, 1);
        chk("midrst_still", graph_still, 1);
        chk("midrst_launch", ball_launch, 0);
        chk("midrst_balls", balls_left, 3);
        for (int i = 0; i < 6; i++) tick();
        chk("midrst_no_launch", launches, snap);
        chk("midrst_idle", text_sel, 1);
`ifdef PONG_CTRL_PAUSE_EN
        btn = 2'b01; step(); btn = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("p_play", graph_still, 0);
        pause_btn = 1; step();
        chk("p_text", text_sel, 3);
        chk("p_still", graph_still, 1);
        miss = 1; step(); miss = 0;
        chk("p_miss_ignored", balls_left, 3);
        pause_btn = 0; step();
        snap = launches;
        pause_btn = 1; step(); pause_btn = 0;
        chk("p_resume", graph_still, 0);
        chk("p_resume_text", text_sel, 0);
        step();
        chk("p_no_launch", launches, snap);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
